pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Parametrised pipeline controller for the openmips core: turns per-stage stall
//  requests, multi-cycle hold requests and flush requests into one stall vector,
//  a flush strobe and a redirect PC. Sits beside pc_reg and the stage registers
//  (if_id, id_ex, ex_mem, mem_wb), which consume stall_output/flush_output.
// PARAMETERS
//  NUM_STAGES  5   pipeline stages after PC (IF,ID,EX,MEM,WB); stall vector is NUM_STAGES+1
//  HOLD_STAGE  3   stage index (1..NUM_STAGES) held by a multi-cycle hold (3 = EX)
//  CNT_WIDTH   6   width of hold_cycles_input and the hold down-counter
//  ADDR_WIDTH  32  PC width
// PORTS
//  clock               in   1             rising-edge clock
//  reset               in   1             synchronous, active-high reset
//  stallreq_input      in   NUM_STAGES    bit i = stage i+1 requests a stall this cycle
//  hold_request        in   1             start a multi-cycle hold of HOLD_STAGE
//  hold_cycles_input   in   CNT_WIDTH     hold length in cycles, incl. the request cycle
//  flush_request       in   1             exception/redirect; sampled at the clock edge
//  flush_pc_input      in   ADDR_WIDTH    redirect target, sampled with flush_request
//  stall_output        out  NUM_STAGES+1  bit0 = PC, bit k = stage-k register holds
//  flush_output        out  1             one-cycle strobe: clear every stage register
//  new_pc_output       out  ADDR_WIDTH    redirect PC, valid while flush_output=1
//  busy_output         out  1             FSM is in HOLD
//  stall_count_output  out  32            stalled-cycle counter (feature-gated)
//  flush_count_output  out  32            flush counter (feature-gated)
// BEHAVIOUR
//  - Reset: state=RUN, counter=0, stall_output=0, flush_output=0, new_pc_output=0,
//    busy_output=0, both count outputs=0. Reset wins over every other input.
//  - FSM states: RUN, HOLD, FLUSH (registered).
//    RUN->FLUSH on flush_request; RUN->HOLD on hold_request && hold_cycles_input>=2
//    (counter<=hold_cycles_input-2); HOLD: counter decrements, ->RUN when counter==0
//    and no flush; HOLD->FLUSH on flush_request (counter cleared); FLUSH->RUN always.
//  - hold_cycles_input==0: request ignored. ==1: stall only in the request cycle, stay RUN.
//  - Effective request vector r = stallreq_input, plus bit HOLD_STAGE-1 when
//    (RUN && hold_request && hold_cycles_input!=0) or state==HOLD.
//  - stall_output (combinational from state + inputs): let k = highest set index of r,
//    plus 1; bits 0..k = 1, the rest 0; all 0 if r==0. The stage after k inserts a bubble.
//  - flush_request has priority over hold_request and stallreq in the same cycle;
//    the request cycle itself still stalls normally.
//  - In FLUSH: flush_output=1, new_pc_output=flush_pc_input sampled on entry,
//    stall_output forced to 0, stallreq/hold inputs ignored; flush_request seen in
//    FLUSH re-enters FLUSH next cycle with the new PC (back-to-back flushes).
//  - Latency: flush_request at edge n -> flush_output high for exactly cycle n+1.
//  - new_pc_output keeps its last value outside FLUSH; consumers qualify it with flush_output.
//  - busy_output = (state==HOLD).
// CONFIGURATION
//  - PIPELINE_CTRL_PERF_EN defined: stall_count_output increments each cycle
//    stall_output[0]==1; flush_count_output increments on each FLUSH entry; both
//    saturate at 32'hFFFF_FFFF and clear on reset.
//  - Undefined: both outputs tied to 0, no counter flops.
// TESTING
//  - Reset held 3 cycles with every request input high -> all outputs 0; state RUN after release.
//  - stallreq_input=5'b00100 (EX), 1 cycle -> stall_output=6'b001111 that cycle only.
//  - hold_request, hold_cycles_input=4 -> stall_output=6'b001111 for 4 cycles,
//    busy_output high for 3 cycles, then 0.
//  - hold_request with hold_cycles_input=0 -> stall_output=0; =1 -> one stall cycle, busy stays 0.
//  - Flush (flush_pc_input=32'h0000_0020) in HOLD cycle 2 -> next cycle flush_output=1,
//    new_pc=32'h20, stall_output=0, then RUN, busy_output=0.
//  - PERF_EN: 4-cycle hold then 2 flushes -> stall_count=4, flush_count=2;
//    macro undefined -> both 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stall, multi-cycle hold and flush requests into a stall vector, flush strobe and redirect PC.
// Optional perf counters are enabled with `define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int HOLD_STAGE = 3,
  parameter int CNT_WIDTH  = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stallreq_input,
  input  logic                  hold_request,
  input  logic [CNT_WIDTH-1:0]  hold_cycles_input,
  input  logic                  flush_request,
  input  logic [ADDR_WIDTH-1:0] flush_pc_input,
  output logic [NUM_STAGES:0]   stall_output,
  output logic                  flush_output,
  output logic [ADDR_WIDTH-1:0] new_pc_output,
  output logic                  busy_output,
  output logic [31:0]           stall_count_output,
  output logic [31:0]           flush_count_output
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] new_pc_q, new_pc_d;
  logic [NUM_STAGES-1:0] req_vec;
  logic [NUM_STAGES:0]   stall_vec;
  logic                  acc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    req_vec  = stallreq_input;
    case (state_q)
      ST_RUN: begin
        if (hold_request && hold_cycles_input != '0) req_vec[HOLD_STAGE-1] = 1'b1;
        if (flush_request) begin
          state_d = ST_FLUSH;
        end else if (hold_request && hold_cycles_input >= CNT_WIDTH'(2)) begin
          // Counter holds the HOLD cycles remaining after this one.
          state_d = ST_HOLD;
          cnt_d   = hold_cycles_input - CNT_WIDTH'(2);
        end
      end
      ST_HOLD: begin
        req_vec[HOLD_STAGE-1] = 1'b1;
        if (flush_request) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        req_vec = '0;
        state_d = flush_request ? ST_FLUSH : ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    if (flush_request) new_pc_d = flush_pc_input;
  end

  // Stage k stalls when any stage at or beyond k requests; PC stalls with any request.
  always_comb begin
    stall_vec = '0;
    acc       = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc              = acc | req_vec[i];
      stall_vec[i + 1] = acc;
    end
    stall_vec[0] = acc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign stall_output  = reset ? '0 : stall_vec;
  assign flush_output  = (state_q == ST_FLUSH);
  assign new_pc_output = new_pc_q;
  assign busy_output   = (state_q == ST_HOLD);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_output[0] && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_d == ST_FLUSH && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count_output = stall_cnt_q;
  assign flush_count_output = flush_cnt_q;
`else
  assign stall_count_output = 32'd0;
  assign flush_count_output = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam int NS = 5;
  localparam int SW = NS + 1;
  localparam int HS = 3;
  localparam int CW = 6;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic [NS-1:0] stallreq_input;
  logic          hold_request;
  logic [CW-1:0] hold_cycles_input;
  logic          flush_request;
  logic [AW-1:0] flush_pc_input;
  logic [SW-1:0] stall_output;
  logic          flush_output;
  logic [AW-1:0] new_pc_output;
  logic          busy_output;
  logic [31:0]   stall_count_output;
  logic [31:0]   flush_count_output;

  int checks = 0;
  int failures = 0;

  // Reference model: pending-flush flag plus number of HOLD cycles still to come.
  bit            m_flush;
  int            m_hold_left;
  logic [AW-1:0] m_pc;
  logic [31:0]   m_stall_cnt;
  logic [31:0]   m_flush_cnt;
  logic [SW-1:0] e_stall;
  logic          e_flush;
  logic          e_busy;

  pipeline_ctrl #(.NUM_STAGES(NS), .HOLD_STAGE(HS), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clock              (clock),
    .reset              (reset),
    .stallreq_input     (stallreq_input),
    .hold_request       (hold_request),
    .hold_cycles_input  (hold_cycles_input),
    .flush_request      (flush_request),
    .flush_pc_input     (flush_pc_input),
    .stall_output       (stall_output),
    .flush_output       (flush_output),
    .new_pc_output      (new_pc_output),
    .busy_output        (busy_output),
    .stall_count_output (stall_count_output),
    .flush_count_output (flush_count_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_eval();
    logic [NS-1:0] r;
    int hi;
    r      = stallreq_input;
    e_busy = (m_hold_left > 0) && !m_flush;
    if (e_busy || (!m_flush && hold_request && hold_cycles_input != 0)) r[HS-1] = 1'b1;
    hi = -1;
    for (int i = 0; i < NS; i++) if (r[i]) hi = i;
    if (reset || m_flush || hi < 0) e_stall = '0;
    else e_stall = SW'((1 << (hi + 2)) - 1);
    e_flush = m_flush;
  endtask

  task automatic model_update();
    if (reset) begin
      m_flush = 0; m_hold_left = 0; m_pc = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
`ifdef PIPELINE_CTRL_PERF_EN
      if (e_stall[0] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (flush_request && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
`endif
      if (flush_request) begin
        m_flush = 1; m_pc = flush_pc_input; m_hold_left = 0;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (m_hold_left > 0) begin
        m_hold_left = m_hold_left - 1;
      end else if (hold_request && hold_cycles_input >= 2) begin
        m_hold_left = int'(hold_cycles_input) - 1;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_input = '0; hold_request = 0; hold_cycles_input = '0;
    flush_request = 0; flush_pc_input = '0;
  endtask

  task automatic test_reset();
    reset = 1; stallreq_input = '1; hold_request = 1; hold_cycles_input = '1;
    flush_request = 1; flush_pc_input = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (stall_output !== '0) begin failures++; $display("FAIL reset_stall c%0d got %b want 0", c, stall_output); end
      checks++; if (flush_output !== 1'b0) begin failures++; $display("FAIL reset_flush c%0d got %b want 0", c, flush_output); end
      checks++; if (new_pc_output !== '0) begin failures++; $display("FAIL reset_pc c%0d got %h want 0", c, new_pc_output); end
      checks++; if (busy_output !== 1'b0) begin failures++; $display("FAIL reset_busy c%0d got %b want 0", c, busy_output); end
      checks++; if (stall_count_output !== 32'd0 || flush_count_output !== 32'd0) begin
        failures++; $display("FAIL reset_counts c%0d got %0d/%0d want 0/0", c, stall_count_output, flush_count_output);
      end
      tick();
    end
    reset = 0; idle_inputs();
    @(negedge clock);
    checks++; if (flush_output !== 1'b0 || busy_output !== 1'b0 || stall_output !== '0) begin
      failures++; $display("FAIL post_reset got flush=%b busy=%b stall=%b want 0/0/0", flush_output, busy_output, stall_output);
    end
    tick();
  endtask

  task automatic test_stallreq();
    stallreq_input = 5'b00100;
    @(negedge clock);
    checks++; if (stall_output !== 6'b001111) begin failures++; $display("FAIL stallreq_ex got %b want 001111", stall_output); end
    tick();
    stallreq_input = '0;
    @(negedge clock);
    checks++; if (stall_output !== 6'b000000) begin failures++; $display("FAIL stallreq_release got %b want 000000", stall_output); end
    tick();
  endtask

  task automatic test_hold4();
    logic [SW-1:0] exp_s [5] = '{6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b000000};
    bit            exp_b [5] = '{0, 1, 1, 1, 0};
    for (int c = 0; c < 5; c++) begin
      hold_request = (c == 0); hold_cycles_input = (c == 0) ? 6'd4 : 6'd0;
      @(negedge clock);
      checks++; if (stall_output !== exp_s[c]) begin failures++; $display("FAIL hold4_stall c%0d got %b want %b", c, stall_output, exp_s[c]); end
      checks++; if (busy_output !== exp_b[c]) begin failures++; $display("FAIL hold4_busy c%0d got %b want %b", c, busy_output, exp_b[c]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_hold_short();
    hold_request = 1; hold_cycles_input = 6'd0;
    @(negedge clock);
    checks++; if (stall_output !== '0) begin failures++; $display("FAIL hold0_stall got %b want 000000", stall_output); end
    tick();
    hold_request = 1; hold_cycles_input = 6'd1;
    @(negedge clock);
    checks++; if (busy_output !== 1'b0) begin failures++; $display("FAIL hold0_busy got %b want 0", busy_output); end
    checks++; if (stall_output !== 6'b001111) begin failures++; $display("FAIL hold1_stall got %b want 001111", stall_output); end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (busy_output !== 1'b0 || stall_output !== '0) begin
      failures++; $display("FAIL hold1_after got busy=%b stall=%b want 0/000000", busy_output, stall_output);
    end
    tick();
  endtask

  task automatic test_flush_in_hold();
    hold_request = 1; hold_cycles_input = 6'd4;
    tick();
    idle_inputs();
    tick();
    flush_request = 1; flush_pc_input = 32'h0000_0020;
    @(negedge clock);
    checks++; if (stall_output !== 6'b001111 || busy_output !== 1'b1) begin
      failures++; $display("FAIL fih_req got stall=%b busy=%b want 001111/1", stall_output, busy_output);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (flush_output !== 1'b1) begin failures++; $display("FAIL fih_flush got %b want 1", flush_output); end
    checks++; if (new_pc_output !== 32'h20) begin failures++; $display("FAIL fih_pc got %h want 00000020", new_pc_output); end
    checks++; if (stall_output !== '0 || busy_output !== 1'b0) begin
      failures++; $display("FAIL fih_quiet got stall=%b busy=%b want 0/0", stall_output, busy_output);
    end
    tick();
    @(negedge clock);
    checks++; if (flush_output !== 1'b0 || busy_output !== 1'b0 || stall_output !== '0) begin
      failures++; $display("FAIL fih_run got flush=%b busy=%b stall=%b want 0/0/0", flush_output, busy_output, stall_output);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    flush_request = 1; flush_pc_input = 32'h100; stallreq_input = 5'b00010;
    @(negedge clock);
    checks++; if (stall_output !== 6'b000111) begin failures++; $display("FAIL b2b_reqcyc got %b want 000111", stall_output); end
    tick();
    flush_pc_input = 32'h200; stallreq_input = '1; hold_request = 1; hold_cycles_input = 6'd5;
    @(negedge clock);
    checks++; if (flush_output !== 1'b1 || new_pc_output !== 32'h100) begin
      failures++; $display("FAIL b2b_first got flush=%b pc=%h want 1/00000100", flush_output, new_pc_output);
    end
    checks++; if (stall_output !== '0) begin failures++; $display("FAIL b2b_ignore got %b want 000000", stall_output); end
    tick();
    flush_request = 0; stallreq_input = '0;
    @(negedge clock);
    checks++; if (flush_output !== 1'b1 || new_pc_output !== 32'h200) begin
      failures++; $display("FAIL b2b_second got flush=%b pc=%h want 1/00000200", flush_output, new_pc_output);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (flush_output !== 1'b0 || busy_output !== 1'b0 || new_pc_output !== 32'h200) begin
      failures++; $display("FAIL b2b_after got flush=%b busy=%b pc=%h want 0/0/00000200", flush_output, busy_output, new_pc_output);
    end
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] exp_sc, exp_fc;
`ifdef PIPELINE_CTRL_PERF_EN
    exp_sc = 32'd4; exp_fc = 32'd2;
`else
    exp_sc = 32'd0; exp_fc = 32'd0;
`endif
    idle_inputs(); reset = 1;
    tick();
    reset = 0;
    hold_request = 1; hold_cycles_input = 6'd4;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) tick();
    flush_request = 1; flush_pc_input = 32'h40;
    tick();
    flush_pc_input = 32'h80;
    tick();
    idle_inputs();
    tick(); tick();
    @(negedge clock);
    checks++; if (stall_count_output !== exp_sc) begin failures++; $display("FAIL perf_stall got %0d want %0d", stall_count_output, exp_sc); end
    checks++; if (flush_count_output !== exp_fc) begin failures++; $display("FAIL perf_flush got %0d want %0d", flush_count_output, exp_fc); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset             = ($urandom_range(0, 59) == 0);
      stallreq_input    = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      hold_request      = ($urandom_range(0, 5) == 0);
      hold_cycles_input = CW'($urandom_range(0, 7));
      flush_request     = ($urandom_range(0, 9) == 0);
      flush_pc_input    = $urandom;
      @(negedge clock);
      model_eval();
      checks++; if (stall_output !== e_stall) begin failures++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall_output, e_stall); end
      checks++; if (flush_output !== e_flush) begin failures++; $display("FAIL rnd_flush c%0d got %b want %b", c, flush_output, e_flush); end
      checks++; if (busy_output !== e_busy) begin failures++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy_output, e_busy); end
      checks++; if (new_pc_output !== m_pc) begin failures++; $display("FAIL rnd_pc c%0d got %h want %h", c, new_pc_output, m_pc); end
      checks++; if (stall_count_output !== m_stall_cnt || flush_count_output !== m_flush_cnt) begin
        failures++; $display("FAIL rnd_counts c%0d got %0d/%0d want %0d/%0d", c, stall_count_output, flush_count_output, m_stall_cnt, m_flush_cnt);
      end
      tick();
    end
    idle_inputs(); reset = 0;
  endtask

  initial begin
    m_flush = 0; m_hold_left = 0; m_pc = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    test_reset();
    test_stallreq();
    test_hold4();
    test_hold_short();
    test_flush_in_hold();
    test_back_to_back();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
